pri_encoder_seq: RTL and testbench
==================================

PRI_ENCODER_SEQ -- requirements
Module: pri_encoder_seq

Interface
REQ-001 Parameter N, default 8: request vector width; legal range 2..64.
REQ-002 Parameter W, default 3: index width; SHALL equal $clog2(N); elaboration SHALL fail otherwise.
REQ-003 Parameter RR, default 0: arbitration mode; 0 = fixed priority, 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 d  input  N  request vector to capture.
REQ-007 load  input  1  capture d into the pending register this edge.
REQ-008 ready  input  1  consumer accepts the current y this edge.
REQ-009 y  output  W  encoded index of the selected pending request.
REQ-010 valid  output  1  pending register non-zero; y is meaningful.
REQ-011 pend  output  N  pending request register.
REQ-012 done  output  1  one-cycle pulse: pending register just emptied by an accept.

Function
REQ-013 Internal state: pending register P (N bits), pointer ptr (W bits, RR=1 only), done register.
REQ-014 y and valid SHALL be decoded combinationally from P and ptr only; no combinational path from d, load or ready to any output.
REQ-015 valid SHALL be 1 iff P != 0.
REQ-016 RR=0: y SHALL be the highest set index of P, as in an 8x3 priority encoder; bit N-1 has highest priority.
REQ-017 RR=1: search order SHALL be ptr, ptr-1, ... 0, N-1, ... ptr+1; y SHALL be the first set index found.
REQ-018 When valid=0, y SHALL be 0.
REQ-019 Accept SHALL be defined as valid & ready at a rising edge.
REQ-020 Next P SHALL be (P & ~onehot(y) when accept, else P) | (d when load, else 0).
REQ-021 If load sets the same bit being accepted, that bit SHALL remain set (load wins).
REQ-022 load with d=0 SHALL leave P unchanged apart from any accept.
REQ-023 Latency: a request loaded at edge k SHALL be visible on pend/valid/y after edge k; accept at edge k updates y after edge k.
REQ-024 While ready=0, y, valid and pend SHALL hold, except for bits OR-ed in by load.
REQ-025 A load of a higher-priority bit while ready=0 SHALL change y on the next cycle; there is no stability guarantee on y before an accept.
REQ-026 RR=1: on accept of index k, ptr SHALL become k-1, wrapping from 0 to N-1; ptr SHALL be unchanged without an accept.
REQ-027 done SHALL be registered and high for exactly the one cycle after an edge where an accept occurred and next P == 0.
REQ-028 done SHALL stay 0 if a load at the same edge keeps P non-zero.
REQ-029 ready with valid=0 SHALL have no effect.

Reset
REQ-030 When rst=1, asynchronously: P=0, done=0, ptr=N-1; hence y=0, valid=0, pend=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending requests immediately, without waiting for clk.
REQ-032 The first edge after rst deasserts SHALL behave as a normal cycle; RR=1 first selection equals fixed priority.

Verification (N=8)
REQ-033 Reset: assert rst with no clock -> y=0, valid=0, pend=8'h00, done=0.
REQ-034 Fixed drain: load d=8'b1010_0100, ready=1 held -> y=7, 5, 2 on consecutive cycles; done=1 for one cycle after the third accept; then valid=0.
REQ-035 Stall: pend=8'b0001_0010, ready=0 for 5 cycles -> y=4 stable, pend unchanged; then load d=8'b0100_0000 -> y=6 next cycle.
REQ-036 Load/accept collision: pend=8'b1000_0000, ready=1, load d=8'b1000_0001 at the same edge -> pend=8'b1000_0001, done=0, y=7.
REQ-037 Round-robin fairness: RR=1, bits 7 and 0 reloaded every cycle, ready=1 -> y=7, 0, 7, 0, ...; the same stimulus with RR=0 -> y=7 on every cycle.
REQ-038 Async reset mid-drain: pend=8'hFF, rst pulsed between edges -> pend=0 and valid=0 before the next edge; the next load of 8'h01 gives y=0, valid=1.

Source files
------------

// File: rtl/pri_encoder_seq.sv
// Sequential priority encoder: captures requests into a pending register and
// hands them out one index at a time, fixed priority or round-robin.
module pri_encoder_seq #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         load,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         done
);

  generate
    if ((W != $clog2(N)) || (N < 2) || (N > 64)) begin : g_param_err
      $error("pri_encoder_seq: N must be 2..64 and W must equal $clog2(N)");
    end
  endgenerate

  logic [N-1:0] p_q, p_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         done_q, done_d;
  logic [W-1:0] base_s, y_s;
  logic [N-1:0] sel_oh_s;
  logic         valid_s, accept_s;
  int           idx_s;

  // Search downward from the start index with wrap; the last hit in loop order is the first in search order.
  always_comb begin
    base_s = (RR != 0) ? ptr_q : W'(N - 1);
    y_s    = '0;
    idx_s  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s = int'(base_s) - k;
      if (idx_s < 0) begin
        idx_s = idx_s + N;
      end else begin
        idx_s = idx_s;
      end
      if (p_q[W'(idx_s)]) begin
        y_s = W'(idx_s);
      end else begin
        y_s = y_s;
      end
    end
  end

  // Next-state: clear the accepted bit, then OR in the load so a reload of that bit wins.
  always_comb begin
    valid_s  = |p_q;
    accept_s = valid_s & ready;
    sel_oh_s = {{(N-1){1'b0}}, 1'b1} << y_s;
    p_d      = (accept_s ? (p_q & ~sel_oh_s) : p_q) | (load ? d : {N{1'b0}});
    done_d   = accept_s & (p_d == {N{1'b0}});
    if ((RR != 0) && accept_s) begin
      ptr_d = (y_s == '0) ? W'(N - 1) : (y_s - W'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      ptr_q  <= W'(N - 1);
      done_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

  assign y     = y_s;
  assign valid = valid_s;
  assign pend  = p_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pri_encoder_seq.sv
// Scoreboard bench for pri_encoder_seq: fixed-priority and round-robin
// instances share stimulus; expectations come from a bench-side model.
module tb_pri_encoder_seq;

  typedef struct packed {
    logic [7:0] pend;
    logic [2:0] y;
    logic       valid;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'h00;
  logic       load = 1'b0;
  logic       ready = 1'b0;
  logic [2:0] y_fp, y_rr;
  logic       valid_fp, valid_rr, done_fp, done_rr;
  logic [7:0] pend_fp, pend_rr;

  int n_chk = 0;
  int n_pass = 0;

  exp_t       q_fp[$];
  exp_t       q_rr[$];
  logic [7:0] mp[2];
  logic [2:0] mptr[2];

  always #5 clk = ~clk;

  pri_encoder_seq #(.N(8), .W(3), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .d(d), .load(load), .ready(ready),
    .y(y_fp), .valid(valid_fp), .pend(pend_fp), .done(done_fp)
  );

  pri_encoder_seq #(.N(8), .W(3), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .d(d), .load(load), .ready(ready),
    .y(y_rr), .valid(valid_rr), .pend(pend_rr), .done(done_rr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference selection: {valid, y}
  function automatic logic [3:0] msel(input logic [7:0] p, input logic [2:0] ptr, input bit rr);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = rr ? ((int'(ptr) - k + 8) % 8) : (7 - k);
      if (p[i]) return {1'b1, 3'(i)};
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mp[m]   = 8'h00;
      mptr[m] = 3'd7;
    end
  endtask

  task automatic cmp_one(input string who, input exp_t e, input logic [7:0] p,
                         input logic [2:0] yy, input logic v, input logic dn);
    chk({who, "_pend"}, 32'(p), 32'(e.pend));
    chk({who, "_y"}, 32'(yy), 32'(e.y));
    chk({who, "_valid"}, 32'(v), 32'(e.valid));
    chk({who, "_done"}, 32'(dn), 32'(e.done));
  endtask

  task automatic step(input logic [7:0] dv, input logic lv, input logic rv);
    exp_t e;
    d = dv; load = lv; ready = rv;
    for (int m = 0; m < 2; m++) begin
      logic [3:0] s;
      logic       acc;
      logic [7:0] np;
      s   = msel(mp[m], mptr[m], m == 1);
      acc = s[3] & rv;
      np  = (acc ? (mp[m] & ~(8'h01 << s[2:0])) : mp[m]) | (lv ? dv : 8'h00);
      if (acc && (m == 1)) mptr[m] = (s[2:0] == 3'd0) ? 3'd7 : (s[2:0] - 3'd1);
      mp[m] = np;
      s = msel(np, mptr[m], m == 1);
      e = '{pend: np, y: s[2:0], valid: s[3], done: (acc && (np == 8'h00))};
      if (m == 0) q_fp.push_back(e);
      else q_rr.push_back(e);
    end
    @(posedge clk);
    #1;
    if (q_fp.size() == 0) chk("sb_fp_empty", 32'd0, 32'd1);
    else cmp_one("fp", q_fp.pop_front(), pend_fp, y_fp, valid_fp, done_fp);
    if (q_rr.size() == 0) chk("sb_rr_empty", 32'd0, 32'd1);
    else cmp_one("rr", q_rr.pop_front(), pend_rr, y_rr, valid_rr, done_rr);
  endtask

  task automatic do_reset();
    d = 8'h00; load = 1'b0; ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset with no clock edge seen yet
    #2;
    chk("rst_y", 32'(y_fp), 32'd0);
    chk("rst_valid", 32'(valid_fp), 32'd0);
    chk("rst_pend", 32'(pend_fp), 32'h00);
    chk("rst_done", 32'(done_fp), 32'd0);
    chk("rst_rr_pend", 32'(pend_rr), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fixed drain
    step(8'b1010_0100, 1'b1, 1'b0);
    chk("drain_y7", 32'(y_fp), 32'd7);
    step(8'h00, 1'b0, 1'b1);
    chk("drain_y5", 32'(y_fp), 32'd5);
    step(8'h00, 1'b0, 1'b1);
    chk("drain_y2", 32'(y_fp), 32'd2);
    step(8'h00, 1'b0, 1'b1);
    chk("drain_done", 32'(done_fp), 32'd1);
    chk("drain_empty", 32'(valid_fp), 32'd0);
    step(8'h00, 1'b0, 1'b1);
    chk("drain_done_pulse", 32'(done_fp), 32'd0);

    // Stall: rr pointer sits at 1 here, so the two instances disagree
    step(8'b0001_0010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0, 1'b0);
      chk("stall_y", 32'(y_fp), 32'd4);
      chk("stall_pend", 32'(pend_fp), 32'h12);
    end
    chk("stall_rr_y", 32'(y_rr), 32'd1);
    step(8'b0100_0000, 1'b1, 1'b0);
    chk("stall_load_y", 32'(y_fp), 32'd6);

    // Load/accept collision
    do_reset();
    step(8'b1000_0000, 1'b1, 1'b0);
    step(8'b1000_0001, 1'b1, 1'b1);
    chk("coll_pend", 32'(pend_fp), 32'h81);
    chk("coll_done", 32'(done_fp), 32'd0);
    chk("coll_y", 32'(y_fp), 32'd7);

    // Round-robin fairness
    do_reset();
    step(8'h81, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("fair_rr_y", 32'(y_rr), (i % 2 == 0) ? 32'd7 : 32'd0);
      chk("fair_fp_y", 32'(y_fp), 32'd7);
      step(8'h81, 1'b1, 1'b1);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset mid-drain
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst_pend", 32'(pend_fp), 32'h00);
    chk("arst_valid", 32'(valid_fp), 32'd0);
    chk("arst_rr_pend", 32'(pend_rr), 32'h00);
    chk("arst_rr_valid", 32'(valid_rr), 32'd0);
    rst = 1'b0;
    model_reset();
    step(8'h01, 1'b1, 1'b0);
    chk("arst_reload_y", 32'(y_fp), 32'd0);
    chk("arst_reload_valid", 32'(valid_fp), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
